store_buffer: RTL
=================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter SB_DEPTH, default 4, number of buffered retired stores (power of two, 2..8).
REQ-002 clock  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 store_command  input  2  BUS_STORE requests an enqueue; BUS_NONE means idle; other encodings are treated as BUS_NONE.
REQ-005 store_size  input  MEM_SIZE  access size of the enqueued store (BYTE/HALF/WORD).
REQ-006 store_addr  input  XLEN  byte address of the enqueued store.
REQ-007 store_data  input  XLEN  store data, right-justified.
REQ-008 store_ready  output  1  high when registered count < SB_DEPTH.
REQ-009 overflow  output  1  sticky flag: an enqueue was attempted while store_ready=0.
REQ-010 load_busy  input  1  load path owns the memory bus this cycle.
REQ-011 mem_command  output  2  BUS_STORE or BUS_NONE to memory.
REQ-012 mem_addr  output  XLEN  head-entry address.
REQ-013 mem_data  output  64  head-entry data, size-masked.
REQ-014 mem_size  output  MEM_SIZE  head-entry size.
REQ-015 mem_response  input  4  nonzero means the request was accepted this cycle; 0 means rejected.
REQ-016 ld_addr  input  XLEN  address of an in-flight load.
REQ-017 ld_conflict  output  1  combinational: some valid entry matches ld_addr[XLEN-1:2].
REQ-018 sb_count  output  4  registered occupancy.
REQ-019 sb_empty  output  1  sb_count==0.

Function
REQ-020 The buffer SHALL be a circular FIFO with head/tail pointers that wrap modulo SB_DEPTH.
REQ-021 An enqueue SHALL occur when store_command==BUS_STORE and store_ready=1, writing {size, addr, data} at tail.
REQ-022 store_ready SHALL be computed from the registered count only; a same-cycle dequeue SHALL NOT admit a push while full.
REQ-023 A rejected push while full SHALL drop the store and set overflow=1 until reset.
REQ-024 The drain FSM SHALL have states IDLE and REQ.
REQ-025 IDLE -> REQ when registered count>0; REQ -> IDLE when a dequeue leaves count 0; otherwise remain in REQ.
REQ-026 In REQ with load_busy=0, mem_command SHALL be BUS_STORE; in IDLE, or when load_busy=1, it SHALL be BUS_NONE.
REQ-027 Dequeue (head advance) SHALL occur only when mem_command==BUS_STORE and mem_response!=0; a zero response SHALL retry the same head next cycle.
REQ-028 mem_data SHALL zero-extend head data masked to size: BYTE [7:0], HALF [15:0], WORD [31:0].
REQ-029 mem_addr, mem_size and mem_data SHALL be stable while the head is not dequeued.
REQ-030 Minimum latency from an enqueue in cycle N to BUS_STORE on the bus SHALL be cycle N+2 (N+1 count update, N+1 IDLE->REQ).
REQ-031 Simultaneous enqueue and dequeue SHALL leave count unchanged, and SHALL preserve FIFO order.
REQ-032 ld_conflict SHALL ignore invalid slots and SHALL NOT include the same-cycle incoming store.
REQ-033 Stores SHALL drain in strict retirement order; the buffer performs no merging or reordering.

Reset
REQ-034 On reset: count=0, head=tail=0, state=IDLE, overflow=0, mem_command=BUS_NONE, sb_empty=1, store_ready=1, ld_conflict=0.
REQ-035 Reset asserted mid-drain SHALL discard all entries, and mem_command SHALL be BUS_NONE in the following cycle.
REQ-036 Data/address storage need not be reset; only valid state matters.

Verification
REQ-037 Single WORD store to 0x100 with data 0xDEADBEEF, mem_response=1 -> BUS_STORE in cycle N+2, mem_data=0x00000000DEADBEEF, then sb_empty=1.
REQ-038 Five stores back-to-back with mem_response=0 -> store_ready=0 after 4, overflow=1 on the 5th, sb_count=4.
REQ-039 Hold load_busy=1 for 3 cycles with 2 stores queued -> BUS_NONE for 3 cycles, then two stores in order A, B.
REQ-040 BYTE store with data 0x12345678 -> mem_data=0x78, mem_size=BYTE.
REQ-041 Entry at 0x204 queued, ld_addr=0x206 -> ld_conflict=1; ld_addr=0x208 -> ld_conflict=0.
REQ-042 Reset while 3 entries pending and a mem_response=0 retry is in progress -> BUS_NONE next cycle, sb_count=0, overflow=0.

Source files
------------

// File: rtl/store_buffer.sv
// store_buffer
//   Circular FIFO of retired stores. A two-state drain FSM presents the head
//   entry to memory until the memory accepts it. The buffer also reports
//   whether an in-flight load overlaps, at word granularity, any store still
//   waiting in the buffer.
//
//   Encodings: command BUS_NONE=0, BUS_STORE=1 (2 and 3 behave as BUS_NONE);
//              size BYTE=0, HALF=1, WORD=2.
//
//   Ports
//     clock, reset              system clock, synchronous active-high reset
//     store_command/size/addr/data  enqueue request from retirement
//     store_ready, overflow     space available / sticky dropped-store flag
//     load_busy                 load path owns the memory bus this cycle
//     mem_command/addr/data/size    head entry presented to memory
//     mem_response              nonzero = request accepted this cycle
//     ld_addr, ld_conflict      load address / word-overlap with a queued store
//     sb_count, sb_empty        registered occupancy
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | buffer was empty last cycle, nothing presented to memory
//   REQ   | head entry is presented to memory (unless load_busy)
module store_buffer #(
    parameter int SB_DEPTH = 4,
    parameter int XLEN     = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      store_command,
    input  logic [1:0]      store_size,
    input  logic [XLEN-1:0] store_addr,
    input  logic [XLEN-1:0] store_data,
    output logic            store_ready,
    output logic            overflow,
    input  logic            load_busy,
    output logic [1:0]      mem_command,
    output logic [XLEN-1:0] mem_addr,
    output logic [63:0]     mem_data,
    output logic [1:0]      mem_size,
    input  logic [3:0]      mem_response,
    input  logic [XLEN-1:0] ld_addr,
    output logic            ld_conflict,
    output logic [3:0]      sb_count,
    output logic            sb_empty
);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd1;
    localparam logic [1:0] SZ_BYTE   = 2'd0;
    localparam logic [1:0] SZ_HALF   = 2'd1;
    localparam int         PW        = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t            state, state_nxt;
    logic [PW-1:0]     head, tail;
    logic [3:0]        count;
    logic [SB_DEPTH-1:0] valid;
    logic [1:0]        sb_size [SB_DEPTH];
    logic [XLEN-1:0]   sb_addr [SB_DEPTH];
    logic [XLEN-1:0]   sb_data [SB_DEPTH];
    logic              push, pop;
    logic [63:0]       head_ext;

    // Ready looks only at the registered count, so a full buffer never takes
    // a push even if the head drains in the same cycle.
    assign store_ready = (count < 4'(SB_DEPTH));
    assign push        = (store_command == BUS_STORE) && store_ready;
    assign pop         = (mem_command == BUS_STORE) && (mem_response != 4'd0);
    assign sb_count    = count;
    assign sb_empty    = (count == 4'd0);

    // FSM: state register
    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (count != 4'd0) state_nxt = S_REQ;
            S_REQ:  if (pop && !push && count == 4'd1) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_command = BUS_NONE;
        if (state == S_REQ && !load_busy) mem_command = BUS_STORE;
    end

    // Pointers, occupancy, per-slot valid bits, sticky overflow.
    // A push and a pop never hit the same slot: that would need count==SB_DEPTH,
    // and a full buffer refuses pushes.
    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= 4'd0;
            valid    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                tail        <= tail + PW'(1);
                valid[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PW'(1);
                valid[head] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (store_command == BUS_STORE && !store_ready) overflow <= 1'b1;
        end
    end

    // Payload storage; contents of invalid slots are don't-care.
    always_ff @(posedge clock) begin
        if (push) begin
            sb_size[tail] <= store_size;
            sb_addr[tail] <= store_addr;
            sb_data[tail] <= store_data;
        end
    end

    assign head_ext = 64'(sb_data[head]);
    assign mem_addr = sb_addr[head];
    assign mem_size = sb_size[head];

    always_comb begin
        case (sb_size[head])
            SZ_BYTE: mem_data = {56'd0, head_ext[7:0]};
            SZ_HALF: mem_data = {48'd0, head_ext[15:0]};
            default: mem_data = {32'd0, head_ext[31:0]};
        endcase
    end

    // Word-granular overlap: the XOR shifted right by two ignores byte offset.
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (valid[i] && (((sb_addr[i] ^ ld_addr) >> 2) == '0)) ld_conflict = 1'b1;
        end
    end

endmodule
